// File: rtl/inp_camera_timing.sv
// Camera-link input stage: polarity-normalised FVAL/LVAL/DVAL + pixel lanes, X/Y tracking, SOF/EOL, frame measurement.
// Latency: 2 cycles pin-to-output for sync/DE/data; X/Y/SOF/EOL/FIELD aligned to that output cycle.
// Backpressure: none; the pixel clock is free-running and every input cycle is consumed.
//
// Ports:
//   CLK, RST                          pixel clock, asynchronous active-high reset
//   iFVAL/iLVAL/iDVAL(_POL)           raw camera strobes and their polarity (1 = active-low)
//   iDATA / oDATA                     CHANNELS*PIXEL_WIDTH pixel lanes (lane 0 in LSBs), delayed 2 cycles
//   iERR_CLR                          clears the sticky oLEN_ERR (a same-cycle new error wins)
//   oVSYNC/oHSYNC/oDE/oFIELD          normalised frame/line/pixel-valid and per-frame field toggle
//   oX/oY/oSOF/oEOL                   pixel/line coordinates and start-of-frame / end-of-line pulses
//   oLINE_LEN/oFRAME_LINES/oLEN_ERR   last completed frame measurements and sticky length error
module inp_camera_timing #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CHANNELS    = 2,
    parameter int H_CNT_WIDTH = 12,
    parameter int V_CNT_WIDTH = 11
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            iFVAL_POL,
    input  logic                            iLVAL_POL,
    input  logic                            iDVAL_POL,
    input  logic                            iFVAL,
    input  logic                            iLVAL,
    input  logic                            iDVAL,
    input  logic [CHANNELS*PIXEL_WIDTH-1:0] iDATA,
    input  logic                            iERR_CLR,
    output logic                            oVSYNC,
    output logic                            oHSYNC,
    output logic                            oDE,
    output logic                            oFIELD,
    output logic [CHANNELS*PIXEL_WIDTH-1:0] oDATA,
    output logic [H_CNT_WIDTH-1:0]          oX,
    output logic [V_CNT_WIDTH-1:0]          oY,
    output logic                            oSOF,
    output logic                            oEOL,
    output logic [H_CNT_WIDTH-1:0]          oLINE_LEN,
    output logic [V_CNT_WIDTH-1:0]          oFRAME_LINES,
    output logic                            oLEN_ERR
);

    localparam int DW = CHANNELS * PIXEL_WIDTH;
    localparam logic [H_CNT_WIDTH-1:0] X_ONE = {{(H_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [V_CNT_WIDTH-1:0] Y_ONE = {{(V_CNT_WIDTH-1){1'b0}}, 1'b1};

    // ST_WAIT: after reset, until FVAL has been seen inactive at the pins, so a
    // frame already in progress when reset releases is never taken as a start.
    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    state_t state, state_next;

    logic          s1_f, s1_l, s1_d;
    logic [DW-1:0] s1_data;
    logic          s1_hs, s1_de;
    logic          f_pin;

    logic                   frame_start, frame_end, frame_end_q;
    logic                   in_frame;
    logic                   line_start, line_end;
    logic                   x_step, x_sat, x_ovf;
    logic [H_CNT_WIDTH-1:0] x_len;
    logic                   y_step, y_sat, y_ovf;
    logic                   len_mis, err_set;
    logic [V_CNT_WIDTH-1:0] line_cnt;
    logic [H_CNT_WIDTH-1:0] ref_len;
    logic                   ref_valid;

    assign f_pin    = iFVAL ^ iFVAL_POL;
    assign s1_hs    = s1_f & s1_l;
    assign s1_de    = s1_hs & s1_d;
    assign in_frame = (state == ST_FRAME);

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            ST_WAIT: begin
                if (!f_pin) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (s1_f && !oVSYNC) begin
                    frame_start = 1'b1;
                    state_next  = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (!s1_f) begin
                    frame_end  = 1'b1;
                    state_next = ST_ARMED;
                end
            end
            default: state_next = ST_WAIT;
        endcase
    end

    // Line edges compare stage 1 against the registered output; a falling
    // FVAL with LVAL high drops s1_hs and so forces the line end.
    assign line_start = (in_frame | frame_start) & s1_hs & ~oHSYNC;
    assign line_end   = in_frame & oHSYNC & ~s1_hs;

    // oX holds the DE count before the current output cycle; x_len folds in
    // the current cycle so it is the complete count at the line-end edge.
    assign x_step = in_frame & oDE;
    assign x_sat  = (oX == '1);
    assign x_ovf  = x_step & x_sat;
    assign x_len  = (x_step && !x_sat) ? oX + X_ONE : oX;

    // oY advances the cycle after oEOL; a frame start in that cycle wins.
    assign y_step = oEOL & ~frame_start;
    assign y_sat  = (oY == '1);
    assign y_ovf  = y_step & y_sat;

    assign len_mis = line_end & ref_valid & (x_len != ref_len);
    assign err_set = x_ovf | y_ovf | len_mis;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= ST_WAIT;
            s1_f         <= 1'b0;
            s1_l         <= 1'b0;
            s1_d         <= 1'b0;
            s1_data      <= '0;
            oVSYNC       <= 1'b0;
            oHSYNC       <= 1'b0;
            oDE          <= 1'b0;
            oDATA        <= '0;
            oSOF         <= 1'b0;
            oEOL         <= 1'b0;
            oFIELD       <= 1'b0;
            oX           <= '0;
            oY           <= '0;
            line_cnt     <= '0;
            ref_len      <= '0;
            ref_valid    <= 1'b0;
            frame_end_q  <= 1'b0;
            oFRAME_LINES <= '0;
            oLINE_LEN    <= '0;
            oLEN_ERR     <= 1'b0;
        end else begin
            state   <= state_next;
            s1_f    <= f_pin;
            s1_l    <= iLVAL ^ iLVAL_POL;
            s1_d    <= iDVAL ^ iDVAL_POL;
            s1_data <= iDATA;

            oVSYNC <= s1_f;
            oHSYNC <= s1_hs;
            oDE    <= s1_de;
            oDATA  <= s1_data;
            oSOF   <= frame_start;
            oEOL   <= line_end;

            if (frame_start) oFIELD <= ~oFIELD;

            if (frame_start || line_start) oX <= '0;
            else if (x_step)               oX <= x_len;

            if (frame_start)          oY <= '0;
            else if (y_step && !y_sat) oY <= oY + Y_ONE;

            if (frame_start) begin
                line_cnt  <= '0;
                ref_len   <= '0;
                ref_valid <= 1'b0;
            end else if (line_end) begin
                if (line_cnt != '1) line_cnt <= line_cnt + Y_ONE;
                if (!ref_valid) begin
                    ref_valid <= 1'b1;
                    ref_len   <= x_len;
                end
            end

            // Published one cycle after the first oVSYNC=0 cycle, by which
            // point the forced line end of the closing edge is counted.
            frame_end_q <= frame_end;
            if (frame_end_q) begin
                oFRAME_LINES <= line_cnt;
                oLINE_LEN    <= ref_valid ? ref_len : '0;
            end

            if (err_set)       oLEN_ERR <= 1'b1;
            else if (iERR_CLR) oLEN_ERR <= 1'b0;
        end
    end

endmodule
